// File: rtl/hypercpu_bus_arbiter.sv
// hypercpu_bus_arbiter
// Two-master round-robin arbiter for the hypercpu memory bus. Decodes the
// granted address into one-hot device enables, inserts per-region wait
// states, captures read data from the shared read bus and returns it to the
// granted master with a single-cycle ready pulse.
//
// Handshake: a master raises req with addr/we/wdata stable and keeps req high
// until it sees ready. Request fields are latched at grant, so later changes
// are ignored. ready (with rdata/err) is high for exactly one cycle. Dropping
// req mid-transaction does not abort it. A master that keeps req high through
// its ready cycle starts a new transaction in the following IDLE cycle.
module hypercpu_bus_arbiter #(
  parameter int ROM_WAIT = 0,
  parameter int RAM_WAIT = 1,
  parameter int IO_WAIT  = 2,
  parameter int WAIT_W   = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        m0_req,
  input  logic [31:0] m0_addr,
  input  logic        m0_we,
  input  logic [31:0] m0_wdata,
  output logic        m0_ready,
  output logic [31:0] m0_rdata,
  output logic        m0_err,
  input  logic        m1_req,
  input  logic [31:0] m1_addr,
  input  logic        m1_we,
  input  logic [31:0] m1_wdata,
  output logic        m1_ready,
  output logic [31:0] m1_rdata,
  output logic        m1_err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_write_data,
  input  logic [31:0] mem_read,
  output logic [3:0]  mem_read_enabled,
  output logic [3:0]  mem_write_enabled
);

  // FSM state; r_state is the observable state for checkers.
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  // Region codes double as bit indices into the enable vectors.
  localparam logic [1:0] REG_ROM  = 2'd0;
  localparam logic [1:0] REG_RAM  = 2'd1;
  localparam logic [1:0] REG_IN   = 2'd2;
  localparam logic [1:0] REG_DISP = 2'd3;

  state_t              r_state;
  state_t              w_next;
  logic [WAIT_W-1:0]   r_cnt;
  logic [31:0]         r_addr;
  logic                r_we;
  logic [31:0]         r_wdata;
  logic                r_gnt;        // 0 = m0, 1 = m1
  logic [1:0]          r_region;
  logic [31:0]         r_rdata;
  logic                r_err;
  logic                r_last_grant;

  logic                w_any_req;
  logic                w_pick_m1;
  logic [31:0]         w_sel_addr;
  logic                w_sel_we;
  logic [31:0]         w_sel_wdata;
  logic [1:0]          w_region;
  logic                w_mapped;
  logic [WAIT_W-1:0]   w_wait;
  logic                w_writable;

  // Arbitration: a lone requester wins; on contention the master that did
  // not win last time gets the bus.
  always_comb begin
    w_any_req   = m0_req | m1_req;
    w_pick_m1   = m1_req & (~m0_req | ~r_last_grant);
    w_sel_addr  = w_pick_m1 ? m1_addr  : m0_addr;
    w_sel_we    = w_pick_m1 ? m1_we    : m0_we;
    w_sel_wdata = w_pick_m1 ? m1_wdata : m0_wdata;
  end

  // Region decode on the top address byte and the matching wait-state load.
  always_comb begin
    w_region = REG_ROM;
    w_mapped = 1'b1;
    w_wait   = WAIT_W'(ROM_WAIT);
    case (w_sel_addr[31:24])
      8'h00: begin w_region = REG_ROM;  w_wait = WAIT_W'(ROM_WAIT); end
      8'h01: begin w_region = REG_RAM;  w_wait = WAIT_W'(RAM_WAIT); end
      8'h90: begin w_region = REG_IN;   w_wait = WAIT_W'(IO_WAIT);  end
      8'hA0: begin w_region = REG_DISP; w_wait = WAIT_W'(IO_WAIT);  end
      default: w_mapped = 1'b0;
    endcase
  end

  // ROM and Input are read-only; writes to them complete without a strobe.
  always_comb begin
    w_writable = (r_region == REG_RAM) || (r_region == REG_DISP);
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next-state logic; unmapped addresses bypass ACCESS.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (w_any_req) w_next = w_mapped ? S_ACCESS : S_DONE;
      S_ACCESS: if (r_cnt == '0) w_next = S_DONE;
      S_DONE:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // Transaction datapath: latch at grant, count wait states, capture read data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt        <= '0;
      r_addr       <= '0;
      r_we         <= 1'b0;
      r_wdata      <= '0;
      r_gnt        <= 1'b0;
      r_region     <= REG_ROM;
      r_rdata      <= '0;
      r_err        <= 1'b0;
      r_last_grant <= 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any_req) begin
            r_addr   <= w_sel_addr;
            r_we     <= w_sel_we;
            r_wdata  <= w_sel_wdata;
            r_gnt    <= w_pick_m1;
            r_region <= w_region;
            r_cnt    <= w_wait;
            r_rdata  <= '0;
            r_err    <= ~w_mapped;
          end
        end
        S_ACCESS: begin
          if (r_cnt == '0) begin
            if (!r_we) r_rdata <= mem_read;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_DONE: r_last_grant <= r_gnt;
        default: ;
      endcase
    end
  end

  // Outputs decoded from state so a reset drops the bus immediately.
  always_comb begin
    mem_addr          = '0;
    mem_write_data    = '0;
    mem_read_enabled  = '0;
    mem_write_enabled = '0;
    m0_ready          = 1'b0;
    m0_rdata          = '0;
    m0_err            = 1'b0;
    m1_ready          = 1'b0;
    m1_rdata          = '0;
    m1_err            = 1'b0;
    case (r_state)
      S_ACCESS: begin
        mem_addr       = r_addr;
        mem_write_data = r_wdata;
        if (!r_we)           mem_read_enabled  = 4'b0001 << r_region;
        else if (w_writable) mem_write_enabled = 4'b0001 << r_region;
      end
      S_DONE: begin
        if (r_gnt) begin
          m1_ready = 1'b1;
          m1_rdata = r_rdata;
          m1_err   = r_err;
        end else begin
          m0_ready = 1'b1;
          m0_rdata = r_rdata;
          m0_err   = r_err;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_hypercpu_bus_arbiter.sv
// Testbench for hypercpu_bus_arbiter: vector table, randomized reads,
// round-robin contention and mid-access reset sequences.
module tb_hypercpu_bus_arbiter;

  localparam int ROM_WAIT = 0;
  localparam int RAM_WAIT = 1;
  localparam int IO_WAIT  = 2;

  logic        clk;
  logic        rst_n;
  logic        m0_req, m1_req;
  logic [31:0] m0_addr, m1_addr;
  logic        m0_we, m1_we;
  logic [31:0] m0_wdata, m1_wdata;
  logic        m0_ready, m1_ready;
  logic [31:0] m0_rdata, m1_rdata;
  logic        m0_err, m1_err;
  logic [31:0] mem_addr, mem_write_data, mem_read;
  logic [3:0]  mem_read_enabled, mem_write_enabled;

  // Device model: the selected device drives the read bus only while enabled.
  logic [31:0] dev_data;
  logic        use_xor;
  assign mem_read = (|mem_read_enabled) ?
                    (use_xor ? (mem_addr ^ 32'hA5A5_0000) : dev_data) : 32'h0;

  hypercpu_bus_arbiter #(
    .ROM_WAIT(ROM_WAIT), .RAM_WAIT(RAM_WAIT), .IO_WAIT(IO_WAIT), .WAIT_W(4)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m0_req), .m0_addr(m0_addr), .m0_we(m0_we), .m0_wdata(m0_wdata),
    .m0_ready(m0_ready), .m0_rdata(m0_rdata), .m0_err(m0_err),
    .m1_req(m1_req), .m1_addr(m1_addr), .m1_we(m1_we), .m1_wdata(m1_wdata),
    .m1_ready(m1_ready), .m1_rdata(m1_rdata), .m1_err(m1_err),
    .mem_addr(mem_addr), .mem_write_data(mem_write_data), .mem_read(mem_read),
    .mem_read_enabled(mem_read_enabled), .mem_write_enabled(mem_write_enabled)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          m;
    logic [31:0] addr;
    bit          we;
    logic [31:0] wdata;
    logic [31:0] dev;
    logic [3:0]  rd_en;
    logic [3:0]  wr_en;
    int          lat;
    int          acc;
    logic [31:0] rdata;
    bit          err;
  } vec_t;

  vec_t        vecs[10];
  logic [32:0] exp_q[$];
  int          n_tests = 0;
  int          n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: event not seen within cycle budget", name);
  endtask

  // Driver tasks
  task automatic drive(input bit m, input bit req, input logic [31:0] a,
                       input bit we, input logic [31:0] wd);
    if (m) begin m1_req = req; m1_addr = a; m1_we = we; m1_wdata = wd; end
    else   begin m0_req = req; m0_addr = a; m0_we = we; m0_wdata = wd; end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  function automatic vec_t mk(input bit m, input logic [31:0] addr, input bit we,
                              input logic [31:0] wdata, input logic [31:0] dev,
                              input logic [3:0] rd_en, input logic [3:0] wr_en,
                              input int lat, input logic [31:0] rdata, input bit err);
    vec_t v;
    v.m = m; v.addr = addr; v.we = we; v.wdata = wdata; v.dev = dev;
    v.rd_en = rd_en; v.wr_en = wr_en; v.lat = lat; v.rdata = rdata; v.err = err;
    v.acc = ((rd_en | wr_en) != 4'b0) ? lat - 1 : 0;
    return v;
  endfunction

  // Issue one transaction, follow it to its ready pulse and check everything.
  task automatic do_txn(input vec_t v);
    bit          seen;
    int          acc;
    logic        rdy, ordy, oerr;
    logic [31:0] rdat;
    logic        err;
    logic [32:0] exp;
    @(negedge clk);
    dev_data = v.dev;
    use_xor  = 1'b0;
    drive(v.m, 1'b1, v.addr, v.we, v.wdata);
    exp_q.push_back({v.err, v.rdata});
    seen = 1'b0;
    acc  = 0;
    for (int k = 1; k <= 20 && !seen; k++) begin
      @(negedge clk);
      rdy  = v.m ? m1_ready : m0_ready;
      rdat = v.m ? m1_rdata : m0_rdata;
      err  = v.m ? m1_err   : m0_err;
      ordy = v.m ? m0_ready : m1_ready;
      oerr = v.m ? m0_err   : m1_err;
      if (rdy) begin
        seen = 1'b1;
        check("latency", k, v.lat);
        check("done_enables", {mem_read_enabled, mem_write_enabled}, 8'h00);
        check("done_bus_idle", {mem_addr, mem_write_data}, 64'h0);
        exp = exp_q.pop_front();
        check("err_rdata", {err, rdat}, exp);
        check("other_master_quiet", {ordy, oerr}, 2'b00);
        drive(v.m, 1'b0, 32'h0, 1'b0, 32'h0);
      end else begin
        if ((mem_read_enabled | mem_write_enabled) != 4'b0) begin
          acc++;
          check("rd_enable", mem_read_enabled, v.rd_en);
          check("wr_enable", mem_write_enabled, v.wr_en);
          check("mem_addr", mem_addr, v.addr);
          check("mem_write_data", mem_write_data, v.wdata);
        end
        // Fields are latched at grant, so scrambling them must not matter.
        if (k == 1) drive(v.m, 1'b1, ~v.addr, ~v.we, ~v.wdata);
      end
    end
    if (!seen) begin
      fail_now("ready_timeout");
      drive(v.m, 1'b0, 32'h0, 1'b0, 32'h0);
      void'(exp_q.pop_front());
    end
    check("access_cycles", acc, v.acc);
    @(negedge clk);
    check("ready_single_pulse", {m0_ready, m1_ready}, 2'b00);
  endtask

  function automatic int wait_of(input int r);
    return (r == 0) ? ROM_WAIT : (r == 1) ? RAM_WAIT : IO_WAIT;
  endfunction

  function automatic logic [7:0] top_of(input int r);
    return (r == 0) ? 8'h00 : (r == 1) ? 8'h01 : (r == 2) ? 8'h90 : 8'hA0;
  endfunction

  initial begin
    rst_n = 1'b0;
    m0_req = 0; m0_addr = 0; m0_we = 0; m0_wdata = 0;
    m1_req = 0; m1_addr = 0; m1_we = 0; m1_wdata = 0;
    dev_data = 0; use_xor = 0;

    vecs[0] = mk(0, 32'h0000_000A, 0, 32'h0,        32'h9C90_0011, 4'b0001, 4'b0000, 2, 32'h9C90_0011, 0);
    vecs[1] = mk(1, 32'h0100_0005, 1, 32'h1234_5678, 32'h0,        4'b0000, 4'b0010, 3, 32'h0,         0);
    vecs[2] = mk(0, 32'h5000_0000, 0, 32'h0,        32'h1111_1111, 4'b0000, 4'b0000, 1, 32'h0,         1);
    vecs[3] = mk(0, 32'h9000_0000, 1, 32'hFFFF_FFFF, 32'h0,        4'b0000, 4'b0000, 4, 32'h0,         0);
    vecs[4] = mk(1, 32'hA000_0003, 0, 32'h0,        32'hDEAD_BEEF, 4'b1000, 4'b0000, 4, 32'hDEAD_BEEF, 0);
    vecs[5] = mk(0, 32'hA000_0010, 1, 32'h0000_55AA, 32'h0,        4'b0000, 4'b1000, 4, 32'h0,         0);
    vecs[6] = mk(1, 32'h01AB_CDEF, 0, 32'h0,        32'h1357_9BDF, 4'b0010, 4'b0000, 3, 32'h1357_9BDF, 0);
    vecs[7] = mk(1, 32'h0000_0004, 1, 32'hCAFE_F00D, 32'h0,        4'b0000, 4'b0000, 2, 32'h0,         0);
    vecs[8] = mk(1, 32'hFF00_0000, 1, 32'h0000_0001, 32'h0,        4'b0000, 4'b0000, 1, 32'h0,         1);
    vecs[9] = mk(0, 32'h9000_0001, 0, 32'h0,        32'h0000_00A5, 4'b0100, 4'b0000, 4, 32'h0000_00A5, 0);

    // Reset state
    repeat (2) @(negedge clk);
    check("reset_ready_err", {m0_ready, m1_ready, m0_err, m1_err}, 4'h0);
    check("reset_rdata", {m0_rdata, m1_rdata}, 64'h0);
    check("reset_bus", {mem_addr, mem_write_data}, 64'h0);
    check("reset_enables", {mem_read_enabled, mem_write_enabled}, 8'h00);
    rst_n = 1'b1;

    // Table-driven vectors
    for (int i = 0; i < 10; i++) do_txn(vecs[i]);

    // Randomized mapped reads
    for (int i = 0; i < 6; i++) begin
      int          r;
      logic [31:0] a, d;
      r = $urandom_range(0, 3);
      a = {top_of(r), 24'($urandom)};
      d = $urandom;
      do_txn(mk(1'($urandom_range(0, 1)), a, 0, 32'h0, d,
                4'b0001 << r, 4'b0000, wait_of(r) + 2, d, 0));
    end

    // Round-robin under continuous contention on RAM reads; m0 wins first after reset.
    do_reset();
    begin
      int  got, last_k;
      @(negedge clk);
      use_xor = 1'b1;
      drive(0, 1'b1, 32'h0100_0100, 1'b0, 32'h0);
      drive(1, 1'b1, 32'h0100_0200, 1'b0, 32'h0);
      for (int j = 0; j < 8; j++)
        exp_q.push_back(j[0] ? {1'b1, 32'h0100_0200 ^ 32'hA5A5_0000}
                             : {1'b0, 32'h0100_0100 ^ 32'hA5A5_0000});
      got = 0;
      last_k = 0;
      for (int k = 1; k <= 60 && got < 8; k++) begin
        @(negedge clk);
        if (m0_ready && m1_ready) check("rr_ready_overlap", 2'b11, 2'b01);
        else if (m0_ready || m1_ready) begin
          logic [32:0] exp;
          exp = exp_q.pop_front();
          check("rr_order_rdata", m1_ready ? {1'b1, m1_rdata} : {1'b0, m0_rdata}, exp);
          check("rr_spacing", k - last_k, (got == 0) ? RAM_WAIT + 2 : RAM_WAIT + 3);
          last_k = k;
          got++;
          if (got == 8) begin
            drive(0, 1'b0, 32'h0, 1'b0, 32'h0);
            drive(1, 1'b0, 32'h0, 1'b0, 32'h0);
          end
        end
      end
      if (got != 8) begin
        fail_now("rr_completions");
        drive(0, 1'b0, 32'h0, 1'b0, 32'h0);
        drive(1, 1'b0, 32'h0, 1'b0, 32'h0);
        exp_q.delete();
      end
      @(negedge clk);
      use_xor = 1'b0;
    end

    // Reset during the second ACCESS cycle of an Input read.
    begin
      bit saw_ready;
      @(negedge clk);
      dev_data = 32'h7777_0000;
      drive(0, 1'b1, 32'h9000_0002, 1'b0, 32'h0);
      @(negedge clk);
      @(negedge clk);
      check("mid_rst_pre_enable", mem_read_enabled, 4'b0100);
      #2 rst_n = 1'b0;
      #1 check("mid_rst_async_enables", {mem_read_enabled, mem_write_enabled, mem_addr}, 40'h0);
      drive(0, 1'b0, 32'h0, 1'b0, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      saw_ready = 1'b0;
      for (int k = 0; k < 6; k++) begin
        @(negedge clk);
        if (m0_ready || m1_ready) saw_ready = 1'b1;
      end
      check("mid_rst_no_ready", saw_ready, 1'b0);
      do_txn(mk(0, 32'h0000_0020, 0, 32'h0, 32'h0BAD_F00D, 4'b0001, 4'b0000,
                ROM_WAIT + 2, 32'h0BAD_F00D, 0));
    end

    check("scoreboard_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/hypercpu_bus_arbiter.md
Name: hypercpu_bus_arbiter

Overview:
Shared memory-bus controller for the hypercpu system bus. It arbitrates between two masters (m0 = CPU, m1 = debug/DMA port), decodes the winning address into one-hot per-device read/write enables for the ROM, RAM, Input and Display regions, and inserts per-region wait states. It captures read data from the shared tristate bus and returns it with a single-cycle ready pulse. It sits between the masters and the device bus. Devices keep their existing mem_addr / mem_read / mem_read_enabled interface, with each device's enable taken from one bit of this block's enable vectors.

Parameters:
ROM_WAIT, 0, extra access cycles for ROM region
RAM_WAIT, 1, extra access cycles for RAM region
IO_WAIT, 2, extra access cycles for Input and Display regions (shared by both)
WAIT_W, 4, width of wait counter; every WAIT parameter must be below 2**WAIT_W

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
m0_req, m1_req  in  1  master requests transaction; held until its ready
m0_addr, m1_addr  in  32  word address
m0_we, m1_we  in  1  1 = write, 0 = read
m0_wdata, m1_wdata  in  32  write data
m0_ready, m1_ready  out  1  one-cycle completion pulse
m0_rdata, m1_rdata  out  32  read data; valid while ready=1
m0_err, m1_err  out  1  pulses with ready when the address is unmapped
mem_addr  out  32  bus address
mem_write_data  out  32  bus write data
mem_read  in  32  shared tristate read bus
mem_read_enabled  out  4  one-hot: [0] ROM, [1] RAM, [2] Input, [3] Display
mem_write_enabled  out  4  same bit order as mem_read_enabled

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: state=IDLE; all ready, err, rdata, mem_addr, mem_write_data and enables = 0; last_grant=1, so m0 wins the first contention.
- Address decode on addr[31:24]:
  - 0x00 = ROM
  - 0x01 = RAM
  - 0x90 = Input
  - 0xA0 = Display
  - anything else = unmapped
- Write filtering: writes to ROM or Input assert no write enable but still complete normally with err=0.
- FSM: IDLE -> ACCESS -> DONE -> IDLE.
- IDLE:
  - If any req is high, grant one master. With a single request, that master wins. With both, the master not equal to last_grant wins (round-robin).
  - On grant, latch addr, we, wdata, master id and region. Load wait counter with the region WAIT value. Go to ACCESS.
  - Unmapped address: skip ACCESS, go straight to DONE with err=1 and rdata=0.
- ACCESS:
  - mem_addr and mem_write_data come from the latched values. Exactly one enable bit is high: read enable if we=0, write enable if we=1 and the region is writable.
  - Counter counts down. The state lasts WAIT+1 cycles.
  - On the final cycle (counter==0), register mem_read into rdata if this is a read. Go to DONE.
- DONE:
  - The granted master's ready=1 for exactly one cycle, with rdata (and err) valid. All enables are already 0.
  - The other master's ready, rdata and err stay 0. Update last_grant. Go to IDLE.
- Latency: a request sampled in IDLE at edge N gives ready high in the cycle after edge N+WAIT+1 (WAIT+2 cycles). Unmapped addresses: 1 cycle.
- Throughput: one transaction per WAIT+3 cycles. A master holding req high after ready issues a new transaction in the next IDLE and must update addr/we/wdata on the ready edge.
- Master protocol: addr, we and wdata are latched at grant, so changes after grant are ignored. Dropping req mid-transaction does not abort it; ready still pulses.
- Bus idle: outside ACCESS, mem_addr=0, mem_write_data=0 and all enables=0, so all devices tristate mem_read.
- Simultaneous requests: both m0_req and m1_req high in IDLE is resolved by the round-robin rule above. The loser waits in place with no timeout.
- Reset mid-transaction: enables drop immediately (asynchronously), no ready is issued, and the FSM restarts in IDLE.

Test Plan:
- ROM_WAIT=0, m0 reads addr 0x0000000A, ROM drives 0x9C900011 -> mem_read_enabled=4'b0001 for 1 cycle; m0_ready 2 cycles after grant with m0_rdata=0x9C900011, err=0.
- m1 writes 0x12345678 to 0x01000005 (RAM_WAIT=1) -> mem_write_enabled=4'b0010 for 2 cycles, mem_addr=0x01000005, mem_write_data=0x12345678; m1_ready 3 cycles after grant.
- m0 and m1 both hold req continuously, reading RAM -> grants strictly alternate m0, m1, m0, m1; no ready overlap; each completes every 4 cycles.
- m0 reads 0x50000000 -> no enable asserted; m0_ready and m0_err pulse together 1 cycle after grant; m0_rdata=0.
- m0 writes 0xFFFFFFFF to 0x90000000 (Input, IO_WAIT=2) -> mem_write_enabled stays 0 for the whole access; m0_ready after 4 cycles with err=0.
- rst_n pulled low during the 2nd ACCESS cycle of an Input read -> enables go to 0 without waiting for a clock edge; no m0_ready; after release, a new m0 ROM read completes normally.
